// File: rtl/alu_muldiv_pkg.sv
// Shared definitions for the M-extension multiply/divide unit.
//   - funct3 encodings of the eight M-extension operations
//   - funct7 value the ALU control decoder uses to route R-type ops here
//   - FSM state encoding used by alu_muldiv_unit
package alu_muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_muldiv_step.sv
// One radix-2 iteration of the multiply/divide datapath (combinational).
// Ports:
//   is_div   in   1       1: restoring divide step, 0: shift-add multiply step
//   acc      in   2*XLEN  multiply: {partial high, multiplier/low product}
//                         divide:   {partial remainder, dividend/quotient}
//   operand  in   XLEN    multiplicand magnitude or divisor magnitude
//   acc_next out  2*XLEN  next accumulator; in divide mode bit 0 is left 0
//                         for the caller to fill with q_bit
//   q_bit    out  1       quotient bit produced by a divide step
module alu_muldiv_step
    import alu_muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                is_div,
    input  logic [2*XLEN-1:0]   acc,
    input  logic [XLEN-1:0]     operand,
    output logic [2*XLEN-1:0]   acc_next,
    output logic                q_bit
);

    logic [XLEN:0] sum;
    logic [XLEN:0] trial;
    logic [XLEN:0] diff;

    always_comb begin
        acc_next = '0;
        q_bit    = 1'b0;
        // Multiply: add multiplicand into the high half when the current
        // multiplier bit is set, then shift the whole accumulator right.
        sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        // Divide: shift the next dividend bit into the partial remainder and
        // try subtracting the divisor; a clear sign bit means it fits.
        trial = acc[2*XLEN-1:XLEN-1];
        diff  = trial - {1'b0, operand};
        if (is_div) begin
            q_bit    = ~diff[XLEN];
            acc_next = {(q_bit ? diff[XLEN-1:0] : trial[XLEN-1:0]), acc[XLEN-2:0], 1'b0};
        end else begin
            acc_next = {sum, acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/alu_muldiv_unit.sv
// Iterative RV M-extension execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, on
// operand magnitudes with a sign fix-up on the final step.
// Optional build macro: ALU_MULDIV_FAST_MUL_EN -- MUL* ops use a combinational
// multiplier at accept and complete like the special divide cases.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   flush             kill the operation in flight
//   in_valid/in_ready request handshake (ready only in IDLE, low during reset)
//   funct3, rs1, rs2  operation and operands, sampled only at accept
//   out_valid/out_ready result handshake; result held stable until taken
//   result            operation result
//   busy              unit is not IDLE
module alu_muldiv_unit
    import alu_muldiv_pkg::*;
#(
    parameter  int unsigned XLEN  = 32,
    localparam int unsigned CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t             state_q, state_d;
    logic [2:0]         op_q;
    logic [XLEN-1:0]    opnd_q;
    logic [2*XLEN-1:0]  acc_q;
    logic               neg_q;
    logic               rneg_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [XLEN-1:0]    result_q;

    logic               accept;
    logic               sign_a, sign_b;
    logic               a_neg, b_neg;
    logic [XLEN-1:0]    mag_a, mag_b;
    logic               div_zero, div_ovf;
    logic [XLEN-1:0]    special_res;
    logic               fast_mul;
    logic [XLEN-1:0]    fast_res;

    logic [2*XLEN-1:0]  step_acc;
    logic               step_q;
    logic [2*XLEN-1:0]  acc_d;
    logic [2*XLEN-1:0]  prod_fix;
    logic [XLEN-1:0]    quo_fix, rem_fix;
    logic [XLEN-1:0]    final_res;

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_DONE) && !rst;
    assign busy      = (state_q != ST_IDLE);
    assign result    = result_q;
    assign accept    = in_valid && in_ready && !flush;

    // Operand decode at accept: sign handling and special divide cases.
    always_comb begin
        sign_a = 1'b0;
        sign_b = 1'b0;
        case (funct3)
            F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
                sign_a = 1'b1;
                sign_b = 1'b1;
            end
            F3_MULHSU: sign_a = 1'b1;
            default: ;
        endcase
        a_neg    = sign_a && rs1[XLEN-1];
        b_neg    = sign_b && rs2[XLEN-1];
        mag_a    = a_neg ? -rs1 : rs1;
        mag_b    = b_neg ? -rs2 : rs2;
        div_zero = funct3[2] && (rs2 == '0);
        div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) && (rs1 == MOST_NEG) && (rs2 == '1);
        special_res = '0;
        // funct3[1] separates REM/REMU from DIV/DIVU.
        if (div_zero) begin
            special_res = funct3[1] ? rs1 : '1;
        end else if (div_ovf) begin
            special_res = funct3[1] ? '0 : rs1;
        end
    end

`ifdef ALU_MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;

    // Sign-extending to 2*XLEN makes the truncated unsigned product equal
    // the low 2*XLEN bits of the true signed/unsigned product.
    always_comb begin
        fast_a    = {{XLEN{sign_a & rs1[XLEN-1]}}, rs1};
        fast_b    = {{XLEN{sign_b & rs2[XLEN-1]}}, rs2};
        fast_prod = fast_a * fast_b;
        fast_res  = (funct3 == F3_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
    assign fast_mul = ~funct3[2];
`else
    assign fast_mul = 1'b0;
    assign fast_res = '0;
`endif

    alu_muldiv_step #(
        .XLEN (XLEN)
    ) u_step (
        .is_div   (op_q[2]),
        .acc      (acc_q),
        .operand  (opnd_q),
        .acc_next (step_acc),
        .q_bit    (step_q)
    );

    // Final-step result: magnitude from the step output, sign applied here.
    always_comb begin
        acc_d    = op_q[2] ? {step_acc[2*XLEN-1:1], step_q} : step_acc;
        prod_fix = neg_q ? -acc_d : acc_d;
        quo_fix  = neg_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
        rem_fix  = rneg_q ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN];
        case (op_q)
            F3_MUL:                       final_res = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              final_res = quo_fix;
            default:                      final_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (div_zero || div_ovf || fast_mul) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (flush || out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q   <= funct3;
            opnd_q <= mag_b;
            acc_q  <= {{XLEN{1'b0}}, mag_a};
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            cnt_q  <= CNT_INIT;
            if (div_zero || div_ovf) begin
                result_q <= special_res;
            end else if (fast_mul) begin
                result_q <= fast_res;
            end
        end else if ((state_q == ST_CALC) && !flush) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
                result_q <= final_res;
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Self-checking bench for alu_muldiv_unit (XLEN=32). Expected results and
// latencies are queued when an operation is accepted and compared when the
// unit presents its result. Honours ALU_MULDIV_FAST_MUL_EN for MUL* latency.
module tb_alu_muldiv_unit;

    localparam int LAT_IT = 33;
    localparam int LAT_SP = 1;
`ifdef ALU_MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    typedef struct {
        string       name;
        logic [31:0] exp;
        int          lat;
        int          acc_cyc;
    } sb_item_t;

    sb_item_t    sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [31:0] last_res = '0;

    alu_muldiv_unit #(
        .XLEN (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .rs1       (rs1),
        .rs2       (rs2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sbv, ua, ub;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        case (f3)
            3'b000: begin p = 64'(sa * sbv); return p[31:0]; end
            3'b001: begin p = 64'(sa * sbv); return p[63:32]; end
            3'b010: begin p = 64'(sa * ub);  return p[63:32]; end
            3'b011: begin p = 64'(ua * ub);  return p[63:32]; end
            3'b100: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sbv);
            end
            3'b101: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return 32'(ua / ub);
            end
            3'b110: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sbv);
            end
            default: begin
                if (b == 32'd0) return a;
                return 32'(ua % ub);
            end
        endcase
    endfunction

    // Result monitor: latency on the rising edge of out_valid, value on handshake.
    initial begin
        logic     ov_prev;
        sb_item_t it;
        ov_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid && !ov_prev) begin
                    if (sb.size() == 0) begin
                        check("spurious_valid", 64'(out_valid), 64'd0);
                    end else begin
                        check({sb[0].name, "_lat"}, 64'(cyc - sb[0].acc_cyc + 1), 64'(sb[0].lat));
                    end
                end
                if (out_valid && out_ready && sb.size() != 0) begin
                    it = sb.pop_front();
                    check(it.name, 64'(result), 64'(it.exp));
                    last_res = it.exp;
                end
            end
            ov_prev = out_valid;
        end
    end

    task automatic issue(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat,
                         input bit sync);
        int       waited;
        sb_item_t it;
        waited = 0;
        if (sync) @(negedge clk);
        funct3   = f3;
        rs1      = a;
        rs2      = b;
        in_valid = 1'b1;
        #1;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            check({name, "_accept"}, 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        it.name    = name;
        it.exp     = exp;
        it.lat     = lat;
        it.acc_cyc = cyc + 1;
        sb.push_back(it);
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs: they must be ignored after accept.
        in_valid = 1'b0;
        funct3   = 3'($urandom);
        rs1      = $urandom;
        rs2      = $urandom;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
        issue(name, f3, a, b, exp, lat, 1'b1);
        drain(80);
    endtask

    initial begin
        int          n;
        logic [2:0]  f3;
        logic [31:0] a, b;
        int          lat;

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        funct3    = '0;
        rs1       = '0;
        rs2       = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;

        // Multiply
        do_op("mul_7_m3",    3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        do_op("mulhu_max",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        do_op("mulhsu_m1_2", 3'b010, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, MUL_LAT);
        do_op("mulh_neg2",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
        // Divide / remainder
        do_op("div_m7_2",    3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, LAT_IT);
        do_op("rem_m7_2",    3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, LAT_IT);
        do_op("divu_100_7",  3'b101, 32'd100,      32'd7,        32'd14,        LAT_IT);
        do_op("remu_100_7",  3'b111, 32'd100,      32'd7,        32'd2,         LAT_IT);
        do_op("div_20_m3",   3'b100, 32'd20,       32'hFFFF_FFFD, 32'hFFFF_FFFA, LAT_IT);
        do_op("rem_20_m3",   3'b110, 32'd20,       32'hFFFF_FFFD, 32'd2,         LAT_IT);
        // Special divide cases
        do_op("divu_5_0",    3'b101, 32'd5,        32'd0,        32'hFFFF_FFFF, LAT_SP);
        do_op("rem_5_0",     3'b110, 32'd5,        32'd0,        32'd5,         LAT_SP);
        do_op("div_5_0",     3'b100, 32'd5,        32'd0,        32'hFFFF_FFFF, LAT_SP);
        do_op("remu_7_0",    3'b111, 32'd7,        32'd0,        32'd7,         LAT_SP);
        do_op("div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SP);
        do_op("rem_ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_SP);

        // Backpressure in DONE
        @(posedge clk);
        #1 out_ready = 1'b0;
        issue("bp_divu", 3'b101, 32'd100, 32'd7, 32'd14, LAT_IT, 1'b1);
        n = 0;
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("bp_reached_done", 64'(out_valid), 64'd1);
        repeat (5) begin
            @(negedge clk);
            check("bp_result", 64'(result), 64'd14);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("bp_idle_in_ready", 64'(in_ready), 64'd1);
        check("bp_idle_out_valid", 64'(out_valid), 64'd0);
        check("bp_popped", 64'(sb.size()), 64'd0);
        issue("bp_next_mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 1'b0);
        drain(80);

        // Flush mid-CALC
        issue("fl_div", 3'b100, 32'hFFFF_FF9C, 32'd3, 32'hFFFF_FFDF, LAT_IT, 1'b1);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("fl_busy", 64'(busy), 64'd0);
        check("fl_out_valid", 64'(out_valid), 64'd0);
        check("fl_in_ready", 64'(in_ready), 64'd1);
        check("fl_result_kept", 64'(result), 64'(last_res));
        void'(sb.pop_front());
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        check("fl_no_valid", 64'(n), 64'd0);

        // Flush in IDLE beats in_valid
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        funct3   = 3'b101;
        rs1      = 32'd100;
        rs2      = 32'd7;
        repeat (3) @(negedge clk);
        check("fl_idle_busy", 64'(busy), 64'd0);
        in_valid = 1'b0;
        flush    = 1'b0;

        // Reset mid-CALC
        issue("rst_mid", 3'b101, 32'd100, 32'd7, 32'd14, LAT_IT, 1'b1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstm_in_ready_async", 64'(in_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("rstm_result", 64'(result), 64'd0);
        check("rstm_in_ready", 64'(in_ready), 64'd0);
        check("rstm_busy", 64'(busy), 64'd0);
        check("rstm_out_valid", 64'(out_valid), 64'd0);
        sb.delete();
        last_res = '0;
        rst = 1'b0;
        #1;
        check("rstm_release_in_ready", 64'(in_ready), 64'd1);
        do_op("post_rst_divu", 3'b101, 32'd100, 32'd7, 32'd14, LAT_IT);

        // Random operations against the arithmetic model
        for (int i = 0; i < 12; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if (!f3[2]) lat = MUL_LAT;
            else if (b == 32'd0) lat = LAT_SP;
            else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) lat = LAT_SP;
            else lat = LAT_IT;
            do_op($sformatf("rnd%0d_f%0d", i, f3), f3, a, b, ref_model(f3, a, b), lat);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
